alu_chain_ctrl: RTL and testbench
=================================

# alu_chain_ctrl

Sequential initiator for the 16-bit combinational ALU. It accepts one wide (WORDS×16-bit) command over a valid/ready handshake and drives the ALU's A/B/F/Cin inputs one 16-bit word per cycle. Carry is chained through the ALU's CF output using ADC/SBB/RCL/RCR. It captures Result and Status each cycle and returns a wide result with merged flags over a valid/ready response channel.

## Interface
- WORDS, 4: number of 16-bit words per operand; legal values 2..8.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  5  ALU opcode (INC, DEC, ADD, ADC, SUB, SBB, AND, OR, XOR, NOT, SHL, SHR, SAL, SAR, ROL, ROR, RCL, RCR)
- cmd_a, cmd_b  in  16*WORDS  operands
- cmd_cin  in  1  carry-in for ADC/SBB/RCL/RCR
- alu_a, alu_b  out  16  word operands to ALU
- alu_f  out  5  opcode to ALU
- alu_cin  out  1  carry to ALU
- alu_result  in  16  ALU Result
- alu_status  in  6  ALU Status {CF,ZF,NF,VF,PF,AF}
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  16*WORDS  wide result
- rsp_status  out  6  merged flags, same bit order as ALU Status
- rsp_illegal  out  1  opcode was not supported

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: cmd_ready=1. When cmd_valid is high, latch the operands, opcode and cin, set idx to the first word, and go to RUN.
  - RUN: one word per cycle. Capture alu_result into the word slot and update the flag accumulators. Go to DONE after word WORDS-1 is processed.
  - DONE: rsp_valid=1. When rsp_ready is high, go to IDLE.
- Word order:
  - Ascending (0 to WORDS-1) for arithmetic, logic, SHL/SAL/ROL/RCL.
  - Descending for SHR/SAR/ROR/RCR.
- Per-step opcode and carry-in (later steps take alu_cin = CF captured on the previous step):
  - ADD/ADC/SUB/SBB: step 0 uses the command opcode with cmd_cin. Later steps use ADC (for ADD/ADC) or SBB (for SUB/SBB).
  - INC/DEC: step 0 uses INC/DEC. Later steps use ADC/SBB with B=0.
  - Logic ops: the same opcode on every word; no chaining.
  - SHL/SAL: step 0 as commanded, then RCL.
  - SHR/SAR: top word as commanded, then RCR.
  - ROL: RCL throughout; step 0 cin = cmd_a MSB.
  - ROR: RCR throughout; first cin = cmd_a[0].
  - RCL/RCR: first cin = cmd_cin.
- Merged flags:
  - ZF = AND of every step's ZF.
  - PF = XNOR of the per-word odd parities, i.e. parity of the full width.
  - NF = NF of the top-word step.
  - CF = CF of the last step.
  - VF = VF of the top-word step, arithmetic only.
  - AF = AF of the word-0 step, arithmetic only.
  - CF, VF and AF are forced to 0 wherever the ALU gives x: CF for logic ops; VF and AF for logic and shift ops.
- Illegal opcode: no RUN state. Go IDLE to DONE directly with rsp_result=0, rsp_status=0, rsp_illegal=1.
- Outside RUN, drive the ALU with alu_f=ADD, alu_a=alu_b=0, alu_cin=0, so its outputs are never x.

## Timing
- Reset values:
  - state IDLE, cmd_ready=1, rsp_valid=0.
  - rsp_result=0, rsp_status=0, rsp_illegal=0.
  - alu_a=alu_b=0, alu_f=ADD, alu_cin=0.
- Latency: rsp_valid rises exactly WORDS+1 edges after the accept edge (WORDS RUN cycles, then DONE). Illegal opcode: rsp_valid rises 1 edge after accept.
- cmd_ready is high only in IDLE. Minimum command spacing is WORDS+2 cycles.
- rsp_* hold stable while rsp_valid=1 and rsp_ready=0.
- The ALU path is combinational within one cycle: alu_* are registered-state decodes, and alu_result is sampled on the same edge.
- rst_n asserted mid-RUN or in DONE: return to the reset values immediately. The partial result is discarded and no response is issued.

## Configuration
- ALU_CHAIN_SHIFT_EN defined: multi-word shift and rotate ops (SHL, SHR, SAL, SAR, ROL, ROR, RCL, RCR) are supported as above.
- ALU_CHAIN_SHIFT_EN undefined: those opcodes take the illegal path and the descending-order logic is removed.

## Structure
- Package alu_pkg holds:
  - 5-bit opcode constants;
  - flag index constants CF=5, ZF=4, NF=3, VF=2, PF=1, AF=0;
  - the FSM state enum.
- Sub-module alu_chain_step: combinational. Maps (cmd_op, step number, WORDS, captured CF, cmd_cin, operand MSB/LSB) to {word index, alu_f, alu_cin, zero-B select, arithmetic/shift class}.

## Test plan
All cases use WORDS=4.
- ADD 0x00000000FFFFFFFF + 1 -> 0x0000000100000000. CF=0, ZF=0, NF=0. rsp_valid 5 edges after accept.
- SUB 0 - 1 -> 0xFFFFFFFFFFFFFFFF. CF=1, NF=1, ZF=0, VF=0.
- ADD 0x7FFFFFFFFFFFFFFF + 1 -> 0x8000000000000000. VF=1, NF=1, CF=0.
- With ALU_CHAIN_SHIFT_EN: SHR 0x0001000000000001 -> 0x0000800000000000, CF=1. Without the macro: rsp_illegal=1, result 0.
- XOR with A=B=0x123456789ABCDEF0 -> 0. ZF=1, PF=1, CF=VF=AF=0. Hold rsp_ready low 3 cycles: outputs stable and cmd_ready=0 throughout.
- Assert rst_n low after 2 RUN cycles: cmd_ready=1 and rsp_valid=0 with no response emitted. Then send cmd_op=5'b11111: rsp_illegal=1 one edge after accept.

Source files
------------

// File: rtl/alu_chain_ctrl_pkg.sv
// Shared constants for the multi-word ALU chaining controller: opcode
// encodings, Status flag bit positions, FSM state encoding and the
// opcode legality check. ALU_CHAIN_SHIFT_EN enables multi-word shifts/rotates.
package alu_pkg;

    // ALU opcodes; 0..9 are arithmetic/logic, 10..17 are shifts and rotates
    localparam logic [4:0] OP_INC = 5'd0;
    localparam logic [4:0] OP_DEC = 5'd1;
    localparam logic [4:0] OP_ADD = 5'd2;
    localparam logic [4:0] OP_ADC = 5'd3;
    localparam logic [4:0] OP_SUB = 5'd4;
    localparam logic [4:0] OP_SBB = 5'd5;
    localparam logic [4:0] OP_AND = 5'd6;
    localparam logic [4:0] OP_OR  = 5'd7;
    localparam logic [4:0] OP_XOR = 5'd8;
    localparam logic [4:0] OP_NOT = 5'd9;
    localparam logic [4:0] OP_SHL = 5'd10;
    localparam logic [4:0] OP_SHR = 5'd11;
    localparam logic [4:0] OP_SAL = 5'd12;
    localparam logic [4:0] OP_SAR = 5'd13;
    localparam logic [4:0] OP_ROL = 5'd14;
    localparam logic [4:0] OP_ROR = 5'd15;
    localparam logic [4:0] OP_RCL = 5'd16;
    localparam logic [4:0] OP_RCR = 5'd17;

    // Bit positions inside the 6-bit Status word {CF,ZF,NF,VF,PF,AF}
    localparam int CF = 5;
    localparam int ZF = 4;
    localparam int NF = 3;
    localparam int VF = 2;
    localparam int PF = 1;
    localparam int AF = 0;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // True when the controller knows how to chain this opcode
    function automatic logic op_legal(input logic [4:0] op);
`ifdef ALU_CHAIN_SHIFT_EN
        return (op <= OP_RCR);
`else
        return (op <= OP_NOT);
`endif
    endfunction

endpackage

// File: rtl/alu_chain_ctrl_step.sv
// Per-step decode for the chaining controller: given the latched opcode and
// the step number, select which 16-bit word is worked on, which opcode and
// carry the ALU sees, and whether B is forced to zero.
// Descending word order exists only when ALU_CHAIN_SHIFT_EN is defined.
module alu_chain_step
    import alu_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic [4:0] op,
    input  logic [2:0] step,
    input  logic       prev_cf,
    input  logic       cmd_cin,
    input  logic       a_msb,
    input  logic       a_lsb,
    output logic [2:0] word_idx,
    output logic [4:0] f,
    output logic       cin,
    output logic       zero_b,
    output logic       is_arith,
    output logic       is_logic
);

    logic first;
    assign first = (step == 3'd0);

`ifdef ALU_CHAIN_SHIFT_EN
    localparam logic [2:0] LAST = 3'(WORDS - 1);
`else
    logic unused_shift_inputs;
    assign unused_shift_inputs = ^{a_msb, a_lsb};
`endif

    // Decode the opcode/carry/word for the current step; later steps chain CF
    always_comb begin
        word_idx = step;
        f        = OP_ADD;
        cin      = 1'b0;
        zero_b   = 1'b0;
        is_arith = 1'b0;
        is_logic = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                is_arith = 1'b1;
                f        = first ? op : OP_ADC;
                cin      = first ? cmd_cin : prev_cf;
            end
            OP_SUB, OP_SBB: begin
                is_arith = 1'b1;
                f        = first ? op : OP_SBB;
                cin      = first ? cmd_cin : prev_cf;
            end
            OP_INC: begin
                is_arith = 1'b1;
                zero_b   = 1'b1;
                f        = first ? OP_INC : OP_ADC;
                cin      = first ? 1'b0 : prev_cf;
            end
            OP_DEC: begin
                is_arith = 1'b1;
                zero_b   = 1'b1;
                f        = first ? OP_DEC : OP_SBB;
                cin      = first ? 1'b0 : prev_cf;
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                is_logic = 1'b1;
                f        = op;
            end
`ifdef ALU_CHAIN_SHIFT_EN
            OP_SHL, OP_SAL: begin
                f   = first ? op : OP_RCL;
                cin = first ? 1'b0 : prev_cf;
            end
            OP_SHR, OP_SAR: begin
                word_idx = LAST - step;
                f        = first ? op : OP_RCR;
                cin      = first ? 1'b0 : prev_cf;
            end
            OP_ROL: begin
                f   = OP_RCL;
                cin = first ? a_msb : prev_cf;
            end
            OP_ROR: begin
                word_idx = LAST - step;
                f        = OP_RCR;
                cin      = first ? a_lsb : prev_cf;
            end
            OP_RCL: begin
                f   = OP_RCL;
                cin = first ? cmd_cin : prev_cf;
            end
            OP_RCR: begin
                word_idx = LAST - step;
                f        = OP_RCR;
                cin      = first ? cmd_cin : prev_cf;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_chain_ctrl.sv
// Sequential initiator for a 16-bit combinational ALU. Takes one WORDS x 16
// bit command, feeds the ALU one word per cycle with CF chained between
// words, and returns the wide result plus merged flags.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; cmd_ready is high only in IDLE, rsp_valid only in DONE, and
// rsp_* stay constant while rsp_valid is high and rsp_ready is low.
// ALU_CHAIN_SHIFT_EN enables multi-word shift/rotate opcodes.
module alu_chain_ctrl
    import alu_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [4:0]            cmd_op,
    input  logic [16*WORDS-1:0]   cmd_a,
    input  logic [16*WORDS-1:0]   cmd_b,
    input  logic                  cmd_cin,
    output logic [15:0]           alu_a,
    output logic [15:0]           alu_b,
    output logic [4:0]            alu_f,
    output logic                  alu_cin,
    input  logic [15:0]           alu_result,
    input  logic [5:0]            alu_status,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [16*WORDS-1:0]   rsp_result,
    output logic [5:0]            rsp_status,
    output logic                  rsp_illegal,
    output logic [1:0]            dbg_state
);

    localparam int         W    = 16 * WORDS;
    localparam logic [2:0] LAST = 3'(WORDS - 1);

    logic [1:0]   state;
    logic [W-1:0] a_q, b_q, res_q;
    logic [4:0]   op_q;
    logic         cin_q, illegal_q;
    logic [2:0]   step;
    // Flag accumulators; odd_acc is the running XOR of per-word odd parity
    logic         cf_q, zf_acc, odd_acc, nf_q, vf_q, af_q;

    logic [2:0]   word_idx;
    logic [4:0]   step_f;
    logic         step_cin, zero_b, is_arith, is_logic;
    logic [15:0]  word_a, word_b;
    logic         show;

    alu_chain_step #(.WORDS(WORDS)) u_step (
        .op       (op_q),
        .step     (step),
        .prev_cf  (cf_q),
        .cmd_cin  (cin_q),
        .a_msb    (a_q[W-1]),
        .a_lsb    (a_q[0]),
        .word_idx (word_idx),
        .f        (step_f),
        .cin      (step_cin),
        .zero_b   (zero_b),
        .is_arith (is_arith),
        .is_logic (is_logic)
    );

    // Pick the operand words addressed by this step
    always_comb begin
        word_a = '0;
        word_b = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (word_idx == 3'(i)) begin
                word_a = a_q[16*i +: 16];
                word_b = b_q[16*i +: 16];
            end
        end
    end

    // Drive the ALU only in RUN; otherwise a benign ADD 0+0 keeps it defined
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_f   = OP_ADD;
        alu_cin = 1'b0;
        if (state == ST_RUN) begin
            alu_a   = word_a;
            alu_b   = zero_b ? 16'd0 : word_b;
            alu_f   = step_f;
            alu_cin = step_cin;
        end
    end

    // FSM, command latch, per-word result capture and flag accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            op_q      <= OP_ADD;
            cin_q     <= 1'b0;
            illegal_q <= 1'b0;
            step      <= 3'd0;
            cf_q      <= 1'b0;
            zf_acc    <= 1'b0;
            odd_acc   <= 1'b0;
            nf_q      <= 1'b0;
            vf_q      <= 1'b0;
            af_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        a_q       <= cmd_a;
                        b_q       <= cmd_b;
                        op_q      <= cmd_op;
                        cin_q     <= cmd_cin;
                        res_q     <= '0;
                        step      <= 3'd0;
                        cf_q      <= 1'b0;
                        zf_acc    <= 1'b1;
                        odd_acc   <= 1'b0;
                        nf_q      <= 1'b0;
                        vf_q      <= 1'b0;
                        af_q      <= 1'b0;
                        illegal_q <= !op_legal(cmd_op);
                        state     <= op_legal(cmd_op) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (word_idx == 3'(i)) begin
                            res_q[16*i +: 16] <= alu_result;
                        end
                    end
                    zf_acc  <= zf_acc & alu_status[ZF];
                    odd_acc <= odd_acc ^ ~alu_status[PF];
                    // Logic ops leave CF undefined in the ALU
                    cf_q    <= is_logic ? 1'b0 : alu_status[CF];
                    if (word_idx == LAST) begin
                        nf_q <= alu_status[NF];
                        vf_q <= is_arith & alu_status[VF];
                    end
                    if (word_idx == 3'd0) begin
                        af_q <= is_arith & alu_status[AF];
                    end
                    if (step == LAST) begin
                        state <= ST_DONE;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state == ST_IDLE);
    assign rsp_valid   = (state == ST_DONE);
    assign show        = rsp_valid & ~illegal_q;
    assign rsp_illegal = rsp_valid & illegal_q;
    assign rsp_result  = show ? res_q : '0;
    assign dbg_state   = state;

    // Assemble merged flags; zero outside DONE and for illegal opcodes
    always_comb begin
        rsp_status = '0;
        if (show) begin
            rsp_status[CF] = cf_q;
            rsp_status[ZF] = zf_acc;
            rsp_status[NF] = nf_q;
            rsp_status[VF] = vf_q;
            rsp_status[PF] = ~odd_acc;
            rsp_status[AF] = af_q;
        end
    end

endmodule

// File: tb/tb_alu_chain_ctrl.sv
// Self-checking bench for alu_chain_ctrl (WORDS=4) with a behavioural 16-bit
// ALU attached. Expected responses come from a 64-bit arithmetic model.
// Shift/rotate expectations follow ALU_CHAIN_SHIFT_EN.
`timescale 1ns/1ps
module tb_alu_chain_ctrl;
    import alu_pkg::*;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;
    localparam int SW    = W + 7;   // {illegal, status[5:0], result}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [4:0]    cmd_op = OP_ADD;
    logic [W-1:0]  cmd_a = '0;
    logic [W-1:0]  cmd_b = '0;
    logic          cmd_cin = 1'b0;
    logic [15:0]   alu_a, alu_b;
    logic [4:0]    alu_f;
    logic          alu_cin;
    logic [15:0]   alu_result;
    logic [5:0]    alu_status;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_result;
    logic [5:0]    rsp_status;
    logic          rsp_illegal;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [SW-1:0] exp_q[$];

    alu_chain_ctrl #(.WORDS(WORDS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_cin     (cmd_cin),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_f       (alu_f),
        .alu_cin     (alu_cin),
        .alu_result  (alu_result),
        .alu_status  (alu_status),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_status  (rsp_status),
        .rsp_illegal (rsp_illegal),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- 16-bit ALU ----------------
    // Flags the real ALU leaves undefined are driven to 1 here so that the
    // controller's forcing to 0 is observable.
    logic [16:0] at;
    logic [15:0] ar, ab;
    logic [4:0]  an;
    logic        ac, acf, avf, aaf;
    always_comb begin
        at  = '0;
        ar  = '0;
        an  = '0;
        acf = 1'b0;
        avf = 1'b0;
        aaf = 1'b0;
        ab  = (alu_f == OP_INC || alu_f == OP_DEC) ? 16'd1 : alu_b;
        ac  = (alu_f == OP_ADC || alu_f == OP_SBB) ? alu_cin : 1'b0;
        case (alu_f)
            OP_INC, OP_ADD, OP_ADC: begin
                at  = {1'b0, alu_a} + {1'b0, ab} + 17'(ac);
                ar  = at[15:0];
                acf = at[16];
                avf = (alu_a[15] == ab[15]) && (ar[15] != alu_a[15]);
                an  = {1'b0, alu_a[3:0]} + {1'b0, ab[3:0]} + 5'(ac);
                aaf = an[4];
            end
            OP_DEC, OP_SUB, OP_SBB: begin
                at  = {1'b0, alu_a} - {1'b0, ab} - 17'(ac);
                ar  = at[15:0];
                acf = at[16];
                avf = (alu_a[15] != ab[15]) && (ar[15] != alu_a[15]);
                an  = {1'b0, alu_a[3:0]} - {1'b0, ab[3:0]} - 5'(ac);
                aaf = an[4];
            end
            OP_AND: begin ar = alu_a & alu_b; acf = 1'b1; avf = 1'b1; aaf = 1'b1; end
            OP_OR:  begin ar = alu_a | alu_b; acf = 1'b1; avf = 1'b1; aaf = 1'b1; end
            OP_XOR: begin ar = alu_a ^ alu_b; acf = 1'b1; avf = 1'b1; aaf = 1'b1; end
            OP_NOT: begin ar = ~alu_a;        acf = 1'b1; avf = 1'b1; aaf = 1'b1; end
            OP_SHL, OP_SAL: begin ar = {alu_a[14:0], 1'b0};       acf = alu_a[15]; avf = 1'b1; aaf = 1'b1; end
            OP_SHR: begin ar = {1'b0, alu_a[15:1]};               acf = alu_a[0];  avf = 1'b1; aaf = 1'b1; end
            OP_SAR: begin ar = {alu_a[15], alu_a[15:1]};          acf = alu_a[0];  avf = 1'b1; aaf = 1'b1; end
            OP_ROL: begin ar = {alu_a[14:0], alu_a[15]};          acf = alu_a[15]; avf = 1'b1; aaf = 1'b1; end
            OP_ROR: begin ar = {alu_a[0], alu_a[15:1]};           acf = alu_a[0];  avf = 1'b1; aaf = 1'b1; end
            OP_RCL: begin ar = {alu_a[14:0], alu_cin};            acf = alu_a[15]; avf = 1'b1; aaf = 1'b1; end
            OP_RCR: begin ar = {alu_cin, alu_a[15:1]};            acf = alu_a[0];  avf = 1'b1; aaf = 1'b1; end
            default: ;
        endcase
        alu_result = ar;
        alu_status = {acf, (ar == 16'd0), ar[15], avf, ~^ar, aaf};
    end

    // ---------------- reference model (full-width arithmetic) ----------------
    function automatic logic [SW-1:0] ref_model(input logic [4:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic cin);
        logic [W:0]   t;
        logic [W-1:0] r, bb;
        logic [4:0]   n;
        logic         c, v, h, legal, cc;
        t = '0; r = '0; n = '0; c = 1'b0; v = 1'b0; h = 1'b0; legal = 1'b1;
        bb = (op == OP_INC || op == OP_DEC) ? W'(1) : b;
        cc = (op == OP_ADC || op == OP_SBB) ? cin : 1'b0;
        case (op)
            OP_INC, OP_ADD, OP_ADC: begin
                t = {1'b0, a} + {1'b0, bb} + (W+1)'(cc);
                r = t[W-1:0]; c = t[W];
                v = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
                n = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + 5'(cc); h = n[4];
            end
            OP_DEC, OP_SUB, OP_SBB: begin
                t = {1'b0, a} - {1'b0, bb} - (W+1)'(cc);
                r = t[W-1:0]; c = t[W];
                v = (a[W-1] != bb[W-1]) && (r[W-1] != a[W-1]);
                n = {1'b0, a[3:0]} - {1'b0, bb[3:0]} - 5'(cc); h = n[4];
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
`ifdef ALU_CHAIN_SHIFT_EN
            OP_SHL, OP_SAL: begin r = a << 1;                    c = a[W-1]; end
            OP_SHR: begin r = a >> 1;                            c = a[0];   end
            OP_SAR: begin r = {a[W-1], a[W-1:1]};                c = a[0];   end
            OP_ROL: begin r = {a[W-2:0], a[W-1]};                c = a[W-1]; end
            OP_ROR: begin r = {a[0], a[W-1:1]};                  c = a[0];   end
            OP_RCL: begin r = {a[W-2:0], cin};                   c = a[W-1]; end
            OP_RCR: begin r = {cin, a[W-1:1]};                   c = a[0];   end
`endif
            default: legal = 1'b0;
        endcase
        if (!legal) return {1'b1, 6'b0, W'(0)};
        return {1'b0, c, (r == '0), r[W-1], v, ~^r, h, r};
    endfunction

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Presents a command, waits for acceptance, then counts edges until
    // rsp_valid, counting the accept edge as the first.
    task automatic send_cmd(input string name, input logic [4:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic cin, output int edges);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check1({name, "_cmd_ready"}, cmd_ready, 1'b1);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        edges = 1;
        while (!rsp_valid && edges < 40) begin
            @(posedge clk); #1; edges++;
        end
    endtask

    task automatic run_one(input string name, input logic [4:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cin, input logic [SW-1:0] exp,
                           input int hold);
        int edges;
        send_cmd(name, op, a, b, cin, edges);
        check1({name, "_rsp_valid"}, rsp_valid, 1'b1);
        check_int({name, "_latency"}, edges, exp[SW-1] ? 1 : WORDS + 1);
        for (int k = 0; k < hold; k++) begin
            check({name, "_hold"}, {rsp_illegal, rsp_status, rsp_result}, exp);
            check1({name, "_hold_cmd_ready"}, cmd_ready, 1'b0);
            @(posedge clk); #1;
        end
        check({name, "_rsp"}, {rsp_illegal, rsp_status, rsp_result}, exp);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check1({name, "_rsp_drop"}, rsp_valid, 1'b0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        string        name;
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        int           hold;
        logic [SW-1:0] expv;
    } vec_t;

    vec_t vecs[10];

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int            quiet_hi;
        int            edges;
        logic [4:0]    rop;
        logic [W-1:0]  ra, rb;
        logic          rc;
        logic [SW-1:0] e;

        vecs[0] = '{"add_carry", OP_ADD, 64'h00000000FFFFFFFF, 64'h1, 1'b0, 0,
                    {1'b0, 6'b000001, 64'h0000000100000000}};
        vecs[1] = '{"sub_borrow", OP_SUB, 64'h0, 64'h1, 1'b0, 1,
                    {1'b0, 6'b101011, 64'hFFFFFFFFFFFFFFFF}};
        vecs[2] = '{"add_ovf", OP_ADD, 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 0,
                    {1'b0, 6'b001101, 64'h8000000000000000}};
`ifdef ALU_CHAIN_SHIFT_EN
        vecs[3] = '{"shr", OP_SHR, 64'h0001000000000001, 64'h0, 1'b0, 0,
                    {1'b0, 6'b100000, 64'h0000800000000000}};
`else
        vecs[3] = '{"shr_illegal", OP_SHR, 64'h0001000000000001, 64'h0, 1'b0, 0,
                    {1'b1, 6'b000000, 64'h0}};
`endif
        vecs[4] = '{"xor_zero_hold", OP_XOR, 64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 1'b0, 3,
                    {1'b0, 6'b010010, 64'h0}};
        vecs[5] = '{"inc_wrap", OP_INC, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0, 0,
                    {1'b0, 6'b110011, 64'h0}};
        vecs[6] = '{"and", OP_AND, 64'hFF00FF00FF00FF00, 64'h0FF00FF00FF00FF0, 1'b0, 0,
                    {1'b0, 6'b000010, 64'h0F000F000F000F00}};
        vecs[7] = '{"adc_cin", OP_ADC, 64'h1, 64'h1, 1'b1, 0,
                    {1'b0, 6'b000010, 64'h3}};
        vecs[8] = '{"sbb_cin", OP_SBB, 64'h5, 64'h2, 1'b1, 2,
                    {1'b0, 6'b000000, 64'h2}};
        vecs[9] = '{"not", OP_NOT, 64'h0, 64'h0, 1'b0, 0,
                    {1'b0, 6'b001010, 64'hFFFFFFFFFFFFFFFF}};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check1("rst_cmd_ready", cmd_ready, 1'b1);
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp", {rsp_illegal, rsp_status, rsp_result}, '0);
        check("rst_alu", SW'({alu_a, alu_b, alu_f, alu_cin}), SW'({16'h0, 16'h0, OP_ADD, 1'b0}));
        check("rst_state", SW'(dbg_state), SW'(ST_IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // table-driven directed vectors
        for (int i = 0; i < 10; i++) begin
            run_one(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
                    vecs[i].expv, vecs[i].hold);
        end

        // reset during RUN discards the command
        send_cmd_abort: begin
            cmd_op = OP_ADD; cmd_a = 64'h1111; cmd_b = 64'h2222; cmd_cin = 1'b0;
            cmd_valid = 1'b1;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            @(posedge clk); @(posedge clk); #1;
            check("abort_in_run", SW'(dbg_state), SW'(ST_RUN));
            rst_n = 1'b0;
            #1;
            check1("abort_cmd_ready", cmd_ready, 1'b1);
            check1("abort_rsp_valid", rsp_valid, 1'b0);
            check("abort_alu_idle", SW'({alu_a, alu_b, alu_f, alu_cin}), SW'({16'h0, 16'h0, OP_ADD, 1'b0}));
            @(posedge clk); #1;
            rst_n = 1'b1;
            quiet_hi = 0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk); #1;
                if (rsp_valid) quiet_hi++;
            end
            check_int("abort_no_response", quiet_hi, 0);
        end
        run_one("illegal_after_reset", 5'b11111, 64'hDEAD, 64'hBEEF, 1'b1,
                {1'b1, 6'b000000, 64'h0}, 0);

        // randomized commands against the reference model
        for (int i = 0; i < 60; i++) begin
            rop = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(18, 31))
                                              : 5'($urandom_range(0, 17));
            ra  = pick_operand();
            rb  = pick_operand();
            rc  = 1'($urandom_range(0, 1));
            exp_q.push_back(ref_model(rop, ra, rb, rc));
            e = exp_q.pop_front();
            run_one($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, rc, e, $urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // back-to-back: two commands with no idle gap
        send_cmd("b2b_first", OP_DEC, 64'h0, 64'h0, 1'b0, edges);
        check_int("b2b_first_latency", edges, WORDS + 1);
        check("b2b_first_rsp", {rsp_illegal, rsp_status, rsp_result},
              ref_model(OP_DEC, 64'h0, 64'h0, 1'b0));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        run_one("b2b_second", OP_OR, 64'hF0F0, 64'h0F0F, 1'b0,
                {1'b0, 6'b000010, 64'hFFFF}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
